// File: rtl/uart_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_loader_if
// Description : Instruction-memory write bus driven by the UART program loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_loader_if;
    logic        mem_wr_en_o;
    logic [31:0] mem_wr_addr_o;
    logic [31:0] mem_wr_data_o;

    modport master (
        output mem_wr_en_o,
        output mem_wr_addr_o,
        output mem_wr_data_o
    );

    modport slave (
        input  mem_wr_en_o,
        input  mem_wr_addr_o,
        input  mem_wr_data_o
    );
endinterface
`default_nettype wire

// File: rtl/uart_loader.sv
`default_nettype none
// ============================================================================
// Module      : uart_loader
// Description : Receives a framed program image over UART (8N1), writes it
//               word-by-word into instruction memory, stalls the core while
//               loading and answers each frame with a one-byte ACK/NAK.
//               Optional trailing XOR checksum: UART_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_loader #(
    parameter int          CLK_FREQ  = 50_000_000,
    parameter int          UART_BPS  = 9600,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  wire           clk,
    input  wire           rst_n,
    input  wire           uart_rx,
    output logic          uart_tx,
    output logic          hold_o,
    output logic          err_o,
    uart_loader_if.master mem
);

    localparam int          c_baud      = CLK_FREQ / UART_BPS;
    localparam logic [31:0] c_bit_last  = 32'(c_baud - 1);
    localparam logic [31:0] c_half_last = 32'(c_baud / 2 - 1);
    localparam logic [7:0]  c_sync      = 8'hA5;
    localparam logic [7:0]  c_ack       = 8'h06;
    localparam logic [7:0]  c_nak       = 8'h15;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [2:0] {
        F_IDLE  = 3'd0,
        F_LEN0  = 3'd1,
        F_LEN1  = 3'd2,
        F_DATA  = 3'd3,
        F_CSUM  = 3'd4,
        F_REPLY = 3'd5
    } frame_state_t;

    // ------------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------------
    logic        r_rx_s1;
    logic        r_rx_s2;
    logic        r_rx_s3;
    rx_state_t   r_rx_state;
    logic [31:0] r_rx_cnt;
    logic [2:0]  r_rx_bit;
    logic [7:0]  r_rx_shift;
    logic        r_byte_valid;
    logic        r_rx_ferr;

    logic w_rx;
    logic w_rx_fall;

    assign w_rx      = r_rx_s2;
    assign w_rx_fall = r_rx_s3 & ~r_rx_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1      <= 1'b1;
            r_rx_s2      <= 1'b1;
            r_rx_s3      <= 1'b1;
            r_rx_state   <= RX_IDLE;
            r_rx_cnt     <= '0;
            r_rx_bit     <= '0;
            r_rx_shift   <= '0;
            r_byte_valid <= 1'b0;
            r_rx_ferr    <= 1'b0;
        end else begin
            r_rx_s1      <= uart_rx;
            r_rx_s2      <= r_rx_s1;
            r_rx_s3      <= r_rx_s2;
            r_byte_valid <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (w_rx_fall) begin
                        r_rx_state <= RX_START;
                        r_rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    // A start bit that is high again at mid-bit was a glitch.
                    if (r_rx_cnt == c_half_last) begin
                        r_rx_cnt <= '0;
                        if (!w_rx) begin
                            r_rx_state <= RX_DATA;
                            r_rx_bit   <= '0;
                        end else begin
                            r_rx_state <= RX_IDLE;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 32'd1;
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == c_bit_last) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {w_rx, r_rx_shift[7:1]};
                        r_rx_bit   <= r_rx_bit + 3'd1;
                        if (r_rx_bit == 3'd7) begin
                            r_rx_state <= RX_STOP;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 32'd1;
                    end
                end
                RX_STOP: begin
                    if (r_rx_cnt == c_bit_last) begin
                        r_rx_cnt     <= '0;
                        r_byte_valid <= 1'b1;
                        r_rx_ferr    <= ~w_rx;
                        r_rx_state   <= RX_IDLE;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 32'd1;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------------
    frame_state_t r_state;
    logic [15:0]  r_len;
    logic [15:0]  r_idx;
    logic [1:0]   r_lane;
    logic [23:0]  r_word;
    logic         r_wr_en;
    logic [31:0]  r_wr_addr;
    logic [31:0]  r_wr_data;
    logic         r_hold;
    logic         r_err;

    logic       w_tx_done;
    logic       w_bv;
    logic       w_ferr;
    logic [7:0] w_byte;

    assign w_bv   = r_byte_valid;
    assign w_ferr = r_rx_ferr;
    assign w_byte = r_rx_shift;

`ifdef UART_LOADER_CHECKSUM_EN
    localparam frame_state_t c_after_data = F_CSUM;

    logic [7:0] r_csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csum <= '0;
        end else if (w_bv) begin
            if (r_state == F_IDLE) begin
                r_csum <= '0;
            end else if (r_state == F_LEN0 || r_state == F_LEN1 || r_state == F_DATA) begin
                r_csum <= r_csum ^ w_byte;
            end
        end
    end
`else
    localparam frame_state_t c_after_data = F_REPLY;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= F_IDLE;
            r_len     <= '0;
            r_idx     <= '0;
            r_lane    <= '0;
            r_word    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_hold    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                F_IDLE: begin
                    if (w_bv && !w_ferr && w_byte == c_sync) begin
                        r_state <= F_LEN0;
                        r_hold  <= 1'b1;
                        r_err   <= 1'b0;
                        r_idx   <= '0;
                        r_lane  <= '0;
                    end
                end
                F_LEN0: begin
                    if (w_bv) begin
                        if (w_ferr) begin
                            r_err   <= 1'b1;
                            r_state <= F_REPLY;
                        end else begin
                            r_len[7:0] <= w_byte;
                            r_state    <= F_LEN1;
                        end
                    end
                end
                F_LEN1: begin
                    if (w_bv) begin
                        if (w_ferr) begin
                            r_err   <= 1'b1;
                            r_state <= F_REPLY;
                        end else begin
                            r_len[15:8] <= w_byte;
                            if ({w_byte, r_len[7:0]} == 16'd0) begin
                                r_state <= c_after_data;
                            end else begin
                                r_state <= F_DATA;
                            end
                        end
                    end
                end
                F_DATA: begin
                    if (w_bv) begin
                        if (w_ferr) begin
                            r_err   <= 1'b1;
                            r_state <= F_REPLY;
                        end else begin
                            r_lane <= r_lane + 2'd1;
                            case (r_lane)
                                2'd0: r_word[7:0]   <= w_byte;
                                2'd1: r_word[15:8]  <= w_byte;
                                2'd2: r_word[23:16] <= w_byte;
                                default: begin
                                    r_wr_en   <= 1'b1;
                                    r_wr_addr <= BASE_ADDR + {14'd0, r_idx, 2'b00};
                                    r_wr_data <= {w_byte, r_word};
                                    r_idx     <= r_idx + 16'd1;
                                    if (r_idx == r_len - 16'd1) begin
                                        r_state <= c_after_data;
                                    end
                                end
                            endcase
                        end
                    end
                end
                F_CSUM: begin
`ifdef UART_LOADER_CHECKSUM_EN
                    if (w_bv) begin
                        if (w_ferr || w_byte != r_csum) begin
                            r_err <= 1'b1;
                        end
                        r_state <= F_REPLY;
                    end
`else
                    r_state <= F_IDLE;
`endif
                end
                F_REPLY: begin
                    // Incoming bytes are dropped here; hold releases with the stop bit.
                    if (w_tx_done) begin
                        r_state <= F_IDLE;
                        r_hold  <= 1'b0;
                    end
                end
                default: r_state <= F_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // TX path: reply launches the cycle after REPLY is entered
    // ------------------------------------------------------------------------
    logic        r_tx_line;
    logic        r_tx_busy;
    logic [7:0]  r_tx_data;
    logic [3:0]  r_tx_bit;
    logic [31:0] r_tx_cnt;

    logic w_tx_start;

    assign w_tx_start = (r_state == F_REPLY) && !r_tx_busy;
    assign w_tx_done  = r_tx_busy && (r_tx_bit == 4'd9) && (r_tx_cnt == c_bit_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_line <= 1'b1;
            r_tx_busy <= 1'b0;
            r_tx_data <= '0;
            r_tx_bit  <= '0;
            r_tx_cnt  <= '0;
        end else if (w_tx_start) begin
            r_tx_busy <= 1'b1;
            r_tx_line <= 1'b0;
            r_tx_data <= r_err ? c_nak : c_ack;
            r_tx_bit  <= '0;
            r_tx_cnt  <= '0;
        end else if (r_tx_busy) begin
            if (r_tx_cnt == c_bit_last) begin
                r_tx_cnt <= '0;
                if (r_tx_bit == 4'd9) begin
                    r_tx_busy <= 1'b0;
                    r_tx_line <= 1'b1;
                end else begin
                    r_tx_bit  <= r_tx_bit + 4'd1;
                    r_tx_line <= (r_tx_bit < 4'd8) ? r_tx_data[r_tx_bit[2:0]] : 1'b1;
                end
            end else begin
                r_tx_cnt <= r_tx_cnt + 32'd1;
            end
        end
    end

    assign uart_tx           = r_tx_line;
    assign hold_o            = r_hold;
    assign err_o             = r_err;
    assign mem.mem_wr_en_o   = r_wr_en;
    assign mem.mem_wr_addr_o = r_wr_addr;
    assign mem.mem_wr_data_o = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_uart_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_loader
// Description : Scoreboard bench for uart_loader: frames are generated from a
//               word-level model; write and reply monitors check independently.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_loader;

    localparam int          CLK_FREQ = 1_000_000;
    localparam int          UART_BPS = 100_000;
    localparam int          BIT_CLKS = CLK_FREQ / UART_BPS;
    localparam logic [31:0] BASE     = 32'h0000_0100;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic uart_rx = 1'b1;
    logic uart_tx;
    logic hold_o;
    logic err_o;

    uart_loader_if u_if ();

    uart_loader #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS),
        .BASE_ADDR(BASE)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .uart_rx(uart_rx),
        .uart_tx(uart_tx),
        .hold_o (hold_o),
        .err_o  (err_o),
        .mem    (u_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_wr[$];
    logic [7:0] exp_rep[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    // Write monitor
    wr_t mon_e;
    always @(negedge clk) begin
        if (rst_n && u_if.mem_wr_en_o) begin
            if (exp_wr.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, expected none",
                         u_if.mem_wr_addr_o, u_if.mem_wr_data_o);
            end else begin
                mon_e = exp_wr.pop_front();
                check("wr_addr", u_if.mem_wr_addr_o, mon_e.addr);
                check("wr_data", u_if.mem_wr_data_o, mon_e.data);
            end
        end
    end

    // Reply monitor
    logic [7:0] tx_byte;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && uart_tx === 1'b0) begin
                repeat (BIT_CLKS / 2) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    repeat (BIT_CLKS) @(negedge clk);
                    tx_byte[k] = uart_tx;
                end
                repeat (BIT_CLKS) @(negedge clk);
                check("tx_stop", {31'd0, uart_tx}, 32'd1);
                if (exp_rep.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_reply: got 0x%02h, expected none", tx_byte);
                end else begin
                    check("reply", {24'd0, tx_byte}, {24'd0, exp_rep.pop_front()});
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        uart_rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            uart_rx = b[k];
            repeat (BIT_CLKS) @(negedge clk);
        end
        uart_rx = stop;
        repeat (BIT_CLKS) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic wait_done(input logic exp_err);
        int t = 0;
        while ((exp_rep.size() != 0 || hold_o) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) begin
            n_tests++;
            n_fail++;
            $display("FAIL frame_timeout: reply/hold still pending after %0d cycles, expected completion", t);
            exp_rep.delete();
        end
        check("hold_released", {31'd0, hold_o}, 32'd0);
        check("err_o", {31'd0, err_o}, {31'd0, exp_err});
        check("writes_drained", exp_wr.size(), 32'd0);
        exp_wr.delete();
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    // Word-level model: word i lands at BASE + 4*i; a clean frame earns an ACK.
    task automatic run_frame(input logic [31:0] words[$]);
        int         n;
        logic [7:0] cs;
        n  = words.size();
        cs = 8'(n) ^ 8'(n >> 8);
        for (int i = 0; i < n; i++) begin
            exp_wr.push_back('{addr: BASE + 32'(4 * i), data: words[i]});
        end
        exp_rep.push_back(8'h06);
        send_byte(8'hA5);
        check("hold_after_sync", {31'd0, hold_o}, 32'd1);
        check("err_after_sync", {31'd0, err_o}, 32'd0);
        send_byte(8'(n));
        send_byte(8'(n >> 8));
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 4; j++) begin
                cs = cs ^ 8'(words[i] >> (8 * j));
                send_byte(8'(words[i] >> (8 * j)));
            end
        end
`ifdef UART_LOADER_CHECKSUM_EN
        send_byte(cs);
`else
        if (cs == 8'h00) uart_rx = 1'b1;
`endif
        wait_done(1'b0);
    endtask

    task automatic random_words(output logic [31:0] q[$], input int n);
        q.delete();
        for (int i = 0; i < n; i++) q.push_back($urandom());
    endtask

    logic [31:0] words[$];
    logic [7:0]  noise;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (5) @(negedge clk);
        check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("rst_wr_en", {31'd0, u_if.mem_wr_en_o}, 32'd0);
        check("rst_wr_addr", u_if.mem_wr_addr_o, 32'd0);
        check("rst_wr_data", u_if.mem_wr_data_o, 32'd0);
        check("rst_hold", {31'd0, hold_o}, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Two-word image
        words = '{32'h1234_5678, 32'hDEAD_BEEF};
        run_frame(words);

        // Noise byte before an empty frame
        send_byte(8'h33);
        check("noise_no_hold", {31'd0, hold_o}, 32'd0);
        words.delete();
        run_frame(words);

        // Framing error on the second data byte
        exp_rep.push_back(8'h15);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h00, 1'b0);
        wait_done(1'b1);
        random_words(words, 2);
        run_frame(words);

`ifdef UART_LOADER_CHECKSUM_EN
        exp_wr.push_back('{addr: BASE, data: 32'h0403_0201});
        exp_rep.push_back(8'h06);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h05);
        wait_done(1'b0);
        exp_wr.push_back('{addr: BASE, data: 32'h0403_0201});
        exp_rep.push_back(8'h15);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h07);
        wait_done(1'b1);
`endif

        // Reset after the second data byte
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        check("hold_mid_frame", {31'd0, hold_o}, 32'd1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("midrst_wr_en", {31'd0, u_if.mem_wr_en_o}, 32'd0);
        check("midrst_wr_addr", u_if.mem_wr_addr_o, 32'd0);
        check("midrst_wr_data", u_if.mem_wr_data_o, 32'd0);
        check("midrst_hold", {31'd0, hold_o}, 32'd0);
        check("midrst_err", {31'd0, err_o}, 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        random_words(words, 3);
        run_frame(words);

        // One-clock glitch in idle
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (300) @(negedge clk);
        check("glitch_hold", {31'd0, hold_o}, 32'd0);
        check("glitch_err", {31'd0, err_o}, 32'd0);
        random_words(words, 1);
        run_frame(words);

        // Randomized frames with optional leading noise
        for (int f = 0; f < 6; f++) begin
            if ($urandom_range(0, 1) == 1) begin
                noise = 8'($urandom_range(0, 255));
                if (noise == 8'hA5) noise = 8'h5A;
                send_byte(noise);
            end
            random_words(words, $urandom_range(0, 4));
            run_frame(words);
        end

        repeat (50) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
